conv_window_sequencer: RTL
==========================

// Module: conv_window_sequencer
// PURPOSE
//  Sequences one image row through a KER_SIZE-column circular line-buffer column store for the conv datapath.
//  - Left pad columns: inserted virtually, consume no input. Right pad columns: same.
//  - Stride: any STRIDE.
//  - Window handshake: valid/ready, with per-tap pad masks and the ring-slot pointer.
//  - Tail real columns that fall after the last window are drained, so the upstream stays row-aligned.
// PARAMETERS
//  KER_SIZE     3   kernel width = column-store depth (slots 0..KER_SIZE-1)
//  INPUT_X_DIM  32  real columns per row
//  PAD          1   pad columns on each side; elaboration error unless PAD<KER_SIZE and KER_SIZE<=INPUT_X_DIM+2*PAD
//  STRIDE       1   horizontal stride, >=1 (honoured only with CWS_STRIDE_EN)
//  Derived (localparams):
//    VX    = INPUT_X_DIM+2*PAD
//    OUT_X = (VX-KER_SIZE)/STRIDE+1   (integer division)
//    PW    = $clog2(VX+1)
//    CPW   = $clog2(KER_SIZE)
// PORTS
//  clk          in   1         clock
//  rstn         in   1         async reset, active low
//  row_start    in   1         pulse: begin a row (abort and restart if one is active)
//  in_valid     in   1         upstream column available
//  in_ready     out  1         column accepted when in_valid&&in_ready; written to slot pos%KER_SIZE
//  win_valid    out  1         window ready for the MAC array
//  win_ready    in   1         MAC array accepts the window
//  win_col_ptr  out  CPW       ring slot of tap 0 (leftmost) = (k*STRIDE)%KER_SIZE
//  win_mask     out  KER_SIZE  bit j=1: tap j is a pad column, MAC must use zero
//  win_x        out  PW        output column index k of the current window
//  row_done     out  1         1-cycle pulse when the row is finished
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0 (in_ready, win_valid, win_mask, win_col_ptr, win_x, row_done).
//  Virtual position counter pos spans 0..VX-1.
//  - Positions p<PAD or p>=PAD+INPUT_X_DIM are pad.
//  - Window k covers positions k*STRIDE .. k*STRIDE+KER_SIZE-1.
//  - win_mask[j] = pad(k*STRIDE+j).
//  FSM (registered state; outputs decoded from state/counters):
//   IDLE:  row_start -> FILL, pos=0, k=0.
//   FILL:  need = k*STRIDE+KER_SIZE.
//          - pos==need -> WIN.
//          - pad(pos): pos++ every cycle, in_ready=0.
//          - real pos: in_ready=1; pos++ on in_valid.
//   WIN:   win_valid=1, in_ready=0. win_mask/win_col_ptr/win_x stable while stalled.
//          - On win_ready: k++.
//          - If k+1==OUT_X -> DRAIN. Otherwise -> FILL.
//   DRAIN: consume real positions until pos==PAD+INPUT_X_DIM (in_ready=1 on real positions only), then -> DONE.
//          Pad positions are skipped; nothing is consumed when no real columns remain.
//   DONE:  row_done=1 for one cycle -> IDLE.
//  Latency (PAD=1, K=3, S=1, in_valid held high, row_start at cycle 0):
//  - win_valid first high at cycle 4.
//  - Next windows: 1 accepted column + 1 cycle each.
//  Boundaries:
//  - row_start in any non-IDLE state: abort. Counters clear, go to FILL next cycle, no row_done pulse.
//    row_start wins over a same-cycle win_ready or in_valid; the window is dropped.
//  - in_valid with in_ready=0: ignored, no consumption.
//  - Columns beyond INPUT_X_DIM are never accepted before the next row_start.
//  - Counters are PW bits and never wrap within a row.
//  - win_col_ptr is computed modulo KER_SIZE, including non-power-of-2 KER_SIZE.
// CONFIGURATION
//  CWS_STRIDE_EN defined:
//  - STRIDE honoured, including STRIDE>KER_SIZE. Skipped columns are consumed but never windowed.
//  CWS_STRIDE_EN undefined:
//  - Effective stride fixed at 1 and STRIDE is ignored.
//  - Advance is a +1 increment (no k*STRIDE multiply); OUT_X=VX-KER_SIZE+1; DRAIN is never entered with real columns left.
// TESTING
//  1) K=3,X=4,P=1,S=1: row_start, in_valid=1, win_ready=1 -> 4 windows.
//     masks 001,000,000,100; col_ptr 0,1,2,0; win_x 0..3; 4 columns accepted; row_done 1 cycle.
//  2) Same config, win_ready low 5 cycles on window 1 -> win_valid held, outputs stable, in_ready=0, no column lost.
//  3) CWS_STRIDE_EN, K=3,X=5,P=1,S=2 -> 3 windows: masks 001,000,100; col_ptr 0,2,1; 5 columns accepted.
//  4) CWS_STRIDE_EN, K=3,X=6,P=0,S=2 -> 2 windows (col_ptr 0,2), then DRAIN accepts 1 column, then row_done.
//  5) Test-1 config, row_start after window 1 accepted -> no row_done; next window mask 001, col_ptr 0, win_x 0.
//  6) rstn low during WIN -> all outputs 0 asynchronously; after release, idle until row_start.

Source files
------------

// File: rtl/conv_window_sequencer.sv
// ============================================================================
//  Module      : conv_window_sequencer
//  Description : Walks one image row through a KER_SIZE-deep circular column
//                store, inserting virtual pad columns and issuing one window
//                per output column to the MAC array over valid/ready.
//                Optional feature macro: CWS_STRIDE_EN (honour STRIDE > 1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_sequencer #(
  parameter int KER_SIZE    = 3,
  parameter int INPUT_X_DIM = 32,
  parameter int PAD         = 1,
  parameter int STRIDE      = 1,
  localparam int VX_L       = INPUT_X_DIM + 2 * PAD,
  localparam int PW_L       = $clog2(VX_L + 1),
  localparam int CPW_L      = (KER_SIZE > 1) ? $clog2(KER_SIZE) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                row_start,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [CPW_L-1:0]    win_col_ptr,
  output logic [KER_SIZE-1:0] win_mask,
  output logic [PW_L-1:0]     win_x,
  output logic                row_done
);

  localparam int VX  = VX_L;
  localparam int PW  = PW_L;
  localparam int CPW = CPW_L;
`ifdef CWS_STRIDE_EN
  localparam int S_EFF = STRIDE;
`else
  localparam int S_EFF = 1;
`endif
  localparam int OUT_X    = (VX - KER_SIZE) / S_EFF + 1;
  localparam int PTR_STEP = S_EFF % KER_SIZE;

  localparam logic [PW:0]   PAD_W  = (PW + 1)'(PAD);
  localparam logic [PW:0]   XDIM_W = (PW + 1)'(INPUT_X_DIM);
  localparam logic [PW:0]   END_W  = (PW + 1)'(PAD + INPUT_X_DIM);
  localparam logic [PW:0]   KER_W  = (PW + 1)'(KER_SIZE);
  localparam logic [PW-1:0] LAST_K = PW'(OUT_X - 1);
  localparam logic [PW-1:0] STEP_W = PW'(S_EFF);
  localparam logic [CPW:0]  PSTEP  = (CPW + 1)'(PTR_STEP);
  localparam logic [CPW:0]  KPTR_W = (CPW + 1)'(KER_SIZE);

  // Reject geometries the column store cannot sequence.
  if (!(PAD < KER_SIZE && KER_SIZE <= VX && STRIDE >= 1)) begin : g_param_check
    $error("conv_window_sequencer: illegal KER_SIZE/PAD/STRIDE/INPUT_X_DIM combination");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WIN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_pos;    // virtual position of the next column
  logic [PW-1:0]     r_base;   // first position of the current window (k*stride)
  logic [PW-1:0]     r_k;      // output column index
  logic [CPW-1:0]    r_ptr;    // ring slot of tap 0

  logic              w_pos_inc, w_win_acc, w_last, w_pos_pad;
  logic [PW:0]       w_need, w_pos_p1;
  logic [CPW:0]      w_ptr_sum;
  logic [CPW-1:0]    w_ptr_nxt;
  logic [KER_SIZE-1:0] w_mask;

  // A position is pad when it lies outside [PAD, PAD+INPUT_X_DIM); the
  // subtraction wraps below PAD so a single unsigned compare covers both sides.
  function automatic logic f_is_pad(input logic [PW:0] p);
    logic [PW:0] rel;
    rel = p - PAD_W;
    return (rel >= XDIM_W);
  endfunction

  assign w_need    = {1'b0, r_base} + KER_W;
  assign w_pos_p1  = {1'b0, r_pos} + (PW + 1)'(1);
  assign w_pos_pad = f_is_pad({1'b0, r_pos});
  assign w_last    = (r_k == LAST_K);
  assign w_ptr_sum = {1'b0, r_ptr} + PSTEP;
  assign w_ptr_nxt = (w_ptr_sum >= KPTR_W) ? CPW'(w_ptr_sum - KPTR_W) : w_ptr_sum[CPW-1:0];

  // Per-tap pad mask of the current window.
  for (genvar j = 0; j < KER_SIZE; j++) begin : g_mask
    logic [PW:0] w_tap_pos;
    assign w_tap_pos = {1'b0, r_base} + (PW + 1)'(j);
    assign w_mask[j] = f_is_pad(w_tap_pos);
  end

  // Next-state and handshake decode; row_start overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    win_valid   = 1'b0;
    row_done    = 1'b0;
    w_pos_inc   = 1'b0;
    w_win_acc   = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_FILL: begin
        if (w_pos_pad) begin
          w_pos_inc = 1'b1;
        end else begin
          in_ready  = 1'b1;
          w_pos_inc = in_valid;
        end
        if (w_pos_inc && (w_pos_p1 == w_need)) w_state_nxt = S_WIN;
      end
      S_WIN: begin
        win_valid = 1'b1;
        if (win_ready) begin
          w_win_acc   = 1'b1;
          w_state_nxt = w_last ? S_DRAIN : S_FILL;
        end
      end
      S_DRAIN: begin
        if ({1'b0, r_pos} >= END_W) begin
          w_state_nxt = S_DONE;
        end else if (w_pos_pad) begin
          w_pos_inc = 1'b1;
        end else begin
          in_ready  = 1'b1;
          w_pos_inc = in_valid;
        end
      end
      S_DONE: begin
        row_done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (row_start) begin
      w_state_nxt = S_FILL;
      in_ready    = 1'b0;
      win_valid   = 1'b0;
      w_pos_inc   = 1'b0;
      w_win_acc   = 1'b0;
    end
  end

  // State and counter registers; window base and ring pointer advance by the stride.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_base  <= '0;
      r_k     <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (row_start) begin
        r_pos  <= '0;
        r_base <= '0;
        r_k    <= '0;
        r_ptr  <= '0;
      end else begin
        if (w_pos_inc) r_pos <= r_pos + PW'(1);
        if (w_win_acc) begin
          r_k <= r_k + PW'(1);
          if (!w_last) begin
            r_base <= r_base + STEP_W;
            r_ptr  <= w_ptr_nxt;
          end
        end
      end
    end
  end

  assign win_mask    = (r_state == S_WIN) ? w_mask : '0;
  assign win_col_ptr = r_ptr;
  assign win_x       = r_k;

endmodule

`default_nettype wire
